// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Drains the read port of a synchronous FIFO and presents the words as a
//   valid/ready stream with packet framing. The last word of every PKT_LEN
//   words is flagged with o_m_last. A 2-entry buffer hides the FIFO's
//   one-cycle read latency, so a word can be handed off every cycle.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset (only acts when i_ce=1)
//   i_ce           clock enable, shared with the attached FIFO
//   i_fifo_r_data  FIFO read data, valid the cycle after a pop
//   i_fifo_empty   FIFO empty flag
//   o_fifo_re      FIFO pop request
//   o_m_data       stream data (head of the buffer)
//   o_m_valid      stream data valid
//   i_m_ready      downstream accepts o_m_data
//   o_m_last       final word of a packet, qualified by o_m_valid
//   o_pkt_idx      position within the packet of the head word
//   o_word_cnt     words handed off since reset, wraps
module fifo_rd_stream #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic [DATA_W-1:0] i_fifo_r_data,
  input  logic              i_fifo_empty,
  output logic              o_fifo_re,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last,
  output logic [CNT_W-1:0]  o_pkt_idx,
  output logic [CNT_W-1:0]  o_word_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  logic [DATA_W-1:0] r_buf [0:1];
  logic [1:0]        r_buf_cnt;
  logic              r_head;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_pkt_idx;
  logic [CNT_W-1:0]  r_word_cnt;

  logic              w_xfer;
  logic [2:0]        w_occ;
  logic              w_tail;

  assign o_m_valid  = (r_buf_cnt != 2'd0);
  assign o_m_data   = r_buf[r_head];
  assign o_m_last   = o_m_valid & (r_pkt_idx == LAST_IDX);
  assign o_pkt_idx  = r_pkt_idx;
  assign o_word_cnt = r_word_cnt;

  assign w_xfer = o_m_valid & i_m_ready;

  // Occupancy the buffer will have after this edge, counting the word still
  // in flight from the FIFO. A pop is only issued if that leaves room, so
  // the 2-entry buffer can never overflow.
  assign w_occ     = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign o_fifo_re = i_ce & ~i_rst & ~i_fifo_empty & (w_occ < 3'd2);

  // Tail slot computed from the pre-edge head/count. When the buffer is full
  // and the head is popped on the same edge, the tail equals the head slot
  // being freed, which keeps the order intact.
  assign w_tail = r_head ^ r_buf_cnt[0];

  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      if (i_rst) begin
        r_buf_cnt  <= 2'd0;
        r_head     <= 1'b0;
        r_inflight <= 1'b0;
        r_pkt_idx  <= '0;
        r_word_cnt <= '0;
      end else begin
        r_inflight <= o_fifo_re;
        if (r_inflight) begin
          r_buf[w_tail] <= i_fifo_r_data;
        end
        if (w_xfer) begin
          r_head     <= ~r_head;
          r_word_cnt <= r_word_cnt + 1'b1;
          r_pkt_idx  <= (r_pkt_idx == LAST_IDX) ? '0 : r_pkt_idx + 1'b1;
        end
        r_buf_cnt <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_xfer};
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int PL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic          m_ready = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd = '0;

  logic          fifo_re, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [CW-1:0] pkt_idx, word_cnt;

  logic          p1_re, p1_valid, p1_last;
  logic [DW-1:0] p1_data;
  logic [CW-1:0] p1_idx, p1_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_W(DW), .PKT_LEN(PL), .CNT_W(CW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_fifo_r_data(fifo_rd), .i_fifo_empty(fifo_empty), .o_fifo_re(fifo_re),
    .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_m_last(m_last), .o_pkt_idx(pkt_idx), .o_word_cnt(word_cnt)
  );

  // Same stimulus with one-word packets: every valid word must be a last word.
  fifo_rd_stream #(.DATA_W(DW), .PKT_LEN(1), .CNT_W(CW)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_fifo_r_data(fifo_rd), .i_fifo_empty(fifo_empty), .o_fifo_re(p1_re),
    .o_m_data(p1_data), .o_m_valid(p1_valid), .i_m_ready(m_ready),
    .o_m_last(p1_last), .o_pkt_idx(p1_idx), .o_word_cnt(p1_cnt)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: FIFO contents, words popped but not yet handed off
  // (in order), packet position and handed-off count.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            model_pos = 0;
  int            model_cnt = 0;
  int            pop_count = 0;

  bit pop_now, xfer_now, rst_now;
  bit prev_hold = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
  endtask

  // Monitor: samples at the falling edge, decides what the next rising edge
  // will do, and checks the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      fifo_empty = (fifo_q.size() == 0);
      #1;
      pop_now  = ce && fifo_re && (fifo_q.size() != 0);
      xfer_now = ce && !rst && m_valid && m_ready;
      rst_now  = ce && rst;

      chk("re_gate", int'(fifo_re & (~ce | fifo_empty | rst)), 0);
      chk("pkt_idx", int'(pkt_idx), model_pos);
      chk("word_cnt", int'(word_cnt), model_cnt % 256);
      chk("last", int'(m_last), int'(m_valid && (model_pos == PL - 1)));

      if (prev_hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(prev_data));
        chk("hold_last", int'(m_last), int'(prev_last));
      end
      prev_hold = m_valid && !xfer_now && !rst_now;
      prev_data = m_data;
      prev_last = m_last;

      if (xfer_now) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", int'(m_data), -1);
        end else begin
          chk("data", int'(m_data), int'(exp_q.pop_front()));
        end
      end

      chk("p1_last", int'(p1_last), int'(p1_valid));
      chk("p1_idx", int'(p1_idx), 0);
      chk("p1_valid", int'(p1_valid), int'(m_valid));
      if (p1_valid) chk("p1_data", int'(p1_data), int'(m_data));
      chk("p1_re", int'(p1_re), int'(fifo_re));
      chk("p1_cnt", int'(p1_cnt), model_cnt % 256);
    end
  end

  // FIFO and model update on the rising edge.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (rst_now) begin
      exp_q.delete();
      model_pos = 0;
      model_cnt = 0;
    end
    if (xfer_now) begin
      model_pos = (model_pos == PL - 1) ? 0 : model_pos + 1;
      model_cnt++;
    end
    if (pop_now) begin
      w = fifo_q.pop_front();
      fifo_rd <= w;
      exp_q.push_back(w);
      pop_count++;
    end else if (ce) begin
      fifo_rd <= DW'($urandom);
    end
  end

  initial begin
    int k, p0, n;
    logic [DW-1:0] d, lastd;
    logic [CW-1:0] wc;

    // Reset with a preloaded FIFO.
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
    cyc(2);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_re", int'(fifo_re), 0);
    chk("rst_idx", int'(pkt_idx), 0);
    chk("rst_cnt", int'(word_cnt), 0);

    // Streaming: first pop to first valid is 2 cycles, then 8 back to back.
    rst = 1'b0;
    m_ready = 1'b1;
    #0;
    chk("first_re", int'(fifo_re), 1);
    k = 0;
    while (!m_valid && k < 6) begin
      cyc(1);
      k++;
    end
    chk("latency", k, 2);
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", int'(m_valid), 1);
      chk("stream_data", int'(m_data), 8'h10 + i);
      chk("stream_last", int'(m_last), int'(i % 4 == 3));
      cyc(1);
    end
    chk("stream_cnt", int'(word_cnt), 8);
    chk("stream_done", int'(m_valid), 0);

    // Backpressure: only two pops while the sink is stalled.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_ready = 1'b0;
    p0 = pop_count;
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
    cyc(8);
    chk("bp_pops", pop_count - p0, 2);
    chk("bp_valid", int'(m_valid), 1);
    chk("bp_data", int'(m_data), 8'h10);
    m_ready = 1'b1;
    cyc(12);

    // FIFO empties mid-packet; framing resumes at the same index.
    push(8'h20);
    push(8'h21);
    cyc(6);
    chk("gap_idx", int'(pkt_idx), 2);
    cyc(10);
    chk("gap_idx_late", int'(pkt_idx), 2);
    lastd = '0;
    n = 0;
    push(8'h22);
    push(8'h23);
    for (int i = 0; i < 8; i++) begin
      if (m_valid && m_last) begin
        lastd = m_data;
        n++;
      end
      cyc(1);
    end
    chk("gap_last_cnt", n, 1);
    chk("gap_last_word", int'(lastd), 8'h23);

    // Clock-enable gating mid-stream.
    for (int i = 0; i < 8; i++) push(DW'(8'h30 + i));
    cyc(4);
    ce = 1'b0;
    #0;
    wc = word_cnt;
    d = m_data;
    for (int i = 0; i < 3; i++) begin
      chk("ce_re", int'(fifo_re), 0);
      chk("ce_cnt", int'(word_cnt), int'(wc));
      chk("ce_data", int'(m_data), int'(d));
      cyc(1);
    end
    ce = 1'b1;
    cyc(12);

    // Reset with a full buffer; buffered words are discarded.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(8'h40 + i));
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_ready = 1'b1;
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_idx", int'(pkt_idx), 0);
    chk("mid_rst_drop", int'(fifo_q.size()), 2);
    cyc(8);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      ce      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 4) push(DW'($urandom));
      cyc(1);
    end

    // Drain: everything popped must come out, nothing extra.
    rst = 1'b0;
    ce = 1'b1;
    m_ready = 1'b1;
    k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_valid) && k < 200) begin
      cyc(1);
      k++;
    end
    chk("drain_timeout", int'(k < 200), 1);
    chk("drain_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
